branch_sequencer: RTL and testbench
===================================

Name: branch_sequencer

Overview:
Multicycle controller that sequences one RV32I B-type instruction through the shared register file, ALU and branch-condition logic. It decodes funct3, requests an ALU subtract rs1-rs2, samples the ALU flags, and evaluates the branch condition. It then writes the next PC (target or PC+4), or raises a trap for illegal or misaligned branches. It sits between the main control FSM (start/done handshake) and the PC register, and keeps taken/total branch counters.

Parameters:
CNT_W, 16, width of the taken-branch and total-branch counters (wrap modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle request from the main FSM; sampled only in IDLE
instr  in  32  instruction word; latched on accepted start
pc_actual  in  32  PC of the instruction; latched on accepted start
rs1_addr  out  5  register-file read address A (latched instr[19:15])
rs2_addr  out  5  register-file read address B (latched instr[24:20])
alu_sub  out  1  request for the ALU to compute rs1-rs2 this cycle
alu_zero  in  1  ALU result == 0
alu_neg  in  1  ALU result bit 31
alu_carry  in  1  carry out of rs1+~rs2+1 (1 => rs1 >= rs2 unsigned)
alu_ovf  in  1  signed overflow of the subtract
pc_next  out  32  next PC value, valid while pc_we=1
pc_we  out  1  PC write strobe, one cycle
tomado  out  1  branch taken; valid in the done cycle and held until next start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse (normal or trap)
illegal  out  1  one-cycle trap pulse, coincident with done
cnt_tomados  out  CNT_W  count of committed taken branches
cnt_total  out  CNT_W  count of committed branches (taken + not taken)

Behaviour:
- Reset (rst=1 at a clock edge, from any state): state=IDLE; rs1_addr=rs2_addr=0; pc_next=0; pc_we=alu_sub=tomado=busy=done=illegal=0; both counters=0. Reset mid-sequence aborts the branch with no PC write.
- States: IDLE -> LECTURA -> COMPARA -> EVALUA -> ESCRIBE -> IDLE. Also IDLE -> TRAP -> IDLE, and EVALUA -> TRAP -> IDLE.
- IDLE: on start=1, latch instr and pc_actual, then decode. If instr[6:0] != 7'b1100011 or funct3 is 010 or 011, go to TRAP. Otherwise go to LECTURA. start is ignored while busy=1.
- LECTURA (cycle 1 after start): rs1_addr/rs2_addr drive the latched fields, which stay stable until the next accepted start. The register file has read latency of 1 cycle.
- COMPARA (cycle 2): alu_sub=1. The four flags are registered at the end of this cycle; flags in other cycles are don't-care.
- EVALUA (cycle 3): compute cond from the registered flags:
  - BEQ(000)=Z; BNE(001)=!Z
  - BLT(100)=N^V; BGE(101)=!(N^V)
  - BLTU(110)=!C; BGEU(111)=C
- EVALUA, immediate: imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- EVALUA, targets: target = pc+imm and fallthrough = pc+4, both mod 2^32.
- EVALUA, next state: if cond=1 and target[1]=1 (misaligned, no C extension), go to TRAP. Otherwise register pc_next = cond ? target : fallthrough and tomado=cond, then go to ESCRIBE.
- ESCRIBE (cycle 4): pc_we=1 and done=1 for exactly this cycle. cnt_total increments by 1 and, if tomado, cnt_tomados increments by 1. Counters wrap.
- TRAP: done=1 and illegal=1 for one cycle; pc_we=0; tomado=0; counters unchanged; return to IDLE.
- Latency: a legal branch gives done 4 cycles after the start cycle. An illegal encoding gives done 1 cycle after start. A misaligned target gives done 4 cycles after start.
- Back-to-back: start in the same cycle done is high is ignored (state is not yet IDLE). The earliest accepted start is the cycle after done.
- pc_next holds its last value outside pc_we.

Test Plan:
- Reset mid-operation: start BEQ, assert rst in COMPARA -> next cycle busy=0, pc_we never pulses, counters=0.
- BEQ taken: pc=0x100, imm=+16, flags Z=1 -> done at start+4 with pc_we=1, pc_next=0x110, tomado=1, cnt_tomados=1, cnt_total=1.
- BNE not taken: pc=0x200, imm=-8, flags Z=1 -> pc_next=0x204, tomado=0, cnt_total increments, cnt_tomados unchanged.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1 (ALU flags N=1,V=0,C=1) -> BLT taken, BLTU not taken, BGE not taken, BGEU taken; taken pc_next = pc+imm.
- Illegal: funct3=010, then opcode 0110011 -> done and illegal at start+1, pc_we=0, counters unchanged. A misaligned taken branch (imm=+6, Z=1, BEQ) -> illegal at start+4, no PC write.
- Handshake: start held high continuously across a branch -> exactly one sequence per IDLE entry, with done pulses spaced 5 cycles apart. Counter wrap with CNT_W=2: the 5th taken branch makes cnt_tomados=1.

Source files
------------

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multicycle sequencer for one RV32I B-type branch
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             one-cycle request from the main FSM, honoured only in IDLE
//   instr, pc_actual  instruction word and its PC, latched on an accepted start
//   rs1_addr/rs2_addr register-file read addresses taken from the latched word
//   alu_sub           asks the shared ALU for rs1-rs2 during COMPARA
//   alu_zero/neg/
//   alu_carry/ovf     ALU flags, registered at the end of COMPARA
//   pc_next, pc_we    next PC value and its one-cycle write strobe
//   tomado            branch taken, held from the done cycle until the next start
//   busy, done        sequencer activity and one-cycle completion pulse
//   illegal           one-cycle trap pulse, coincident with done
//   cnt_tomados       committed taken branches (wraps)
//   cnt_total         committed branches, taken or not (wraps)

module branch_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc_actual,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic             alu_sub,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic [31:0]      pc_next,
  output logic             pc_we,
  output logic             tomado,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] cnt_tomados,
  output logic [CNT_W-1:0] cnt_total
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LECTURA = 3'd1,
    S_COMPARA = 3'd2,
    S_EVALUA  = 3'd3,
    S_ESCRIBE = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  state_t state, state_nxt;

  // The opcode is only needed for the decode in IDLE, so bits [6:0] are not kept.
  logic [31:7] instr_q;
  logic [31:0] pc_q;
  logic        flag_z, flag_n, flag_c, flag_v;

  logic        accept;
  logic        enc_ok;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic [31:0] target;
  logic [31:0] fallthrough;
  logic        cond;
  logic        misaligned;

  assign accept = (state == S_IDLE) && start;

  // funct3 010 and 011 are the two reserved branch encodings.
  assign enc_ok = (instr[6:0] == OPC_BRANCH) && (instr[14:13] != 2'b01);

  assign rs1_addr = instr_q[19:15];
  assign rs2_addr = instr_q[24:20];
  assign funct3   = instr_q[14:12];

  assign imm = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign target      = pc_q + imm;
  assign fallthrough = pc_q + 32'd4;

  // Condition from the flags of rs1-rs2: signed less-than is N xor V,
  // unsigned greater-or-equal is the carry out of the subtract.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = flag_z;
      3'b001:  cond = !flag_z;
      3'b100:  cond = flag_n ^ flag_v;
      3'b101:  cond = !(flag_n ^ flag_v);
      3'b110:  cond = !flag_c;
      3'b111:  cond = flag_c;
      default: cond = 1'b0;
    endcase
  end

  // Without the C extension a taken target must be word aligned; bit 0 of
  // the target is always zero, so only bit 1 can be wrong.
  assign misaligned = cond && target[1];

  always_comb begin
    state_nxt = state;
    alu_sub   = 1'b0;
    pc_we     = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = enc_ok ? S_LECTURA : S_TRAP;
        end
      end
      S_LECTURA: begin
        state_nxt = S_COMPARA;
      end
      S_COMPARA: begin
        alu_sub   = 1'b1;
        state_nxt = S_EVALUA;
      end
      S_EVALUA: begin
        state_nxt = misaligned ? S_TRAP : S_ESCRIBE;
      end
      S_ESCRIBE: begin
        pc_we     = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_TRAP: begin
        done      = 1'b1;
        illegal   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      pc_q        <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
      pc_next     <= '0;
      tomado      <= 1'b0;
      cnt_tomados <= '0;
      cnt_total   <= '0;
    end else begin
      if (accept) begin
        instr_q <= instr[31:7];
        pc_q    <= pc_actual;
        tomado  <= 1'b0;
      end
      if (state == S_COMPARA) begin
        flag_z <= alu_zero;
        flag_n <= alu_neg;
        flag_c <= alu_carry;
        flag_v <= alu_ovf;
      end
      // Commit on the way into ESCRIBE so the counters already show the
      // new branch during the done cycle. A trap leaves tomado at the 0
      // written on start.
      if (state == S_EVALUA && !misaligned) begin
        pc_next   <= cond ? target : fallthrough;
        tomado    <= cond;
        cnt_total <= cnt_total + CNT_W'(1);
        if (cond) begin
          cnt_tomados <= cnt_tomados + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer

module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] instr;
  logic [31:0] pc_actual;
  logic        alu_zero, alu_neg, alu_carry, alu_ovf;

  logic [4:0]  rs1_addr, rs2_addr;
  logic        alu_sub, pc_we, tomado, busy, done, illegal;
  logic [31:0] pc_next;
  logic [15:0] cnt_tomados, cnt_total;

  logic [4:0]  s_rs1_addr, s_rs2_addr;
  logic        s_alu_sub, s_pc_we, s_tomado, s_busy, s_done, s_illegal;
  logic [31:0] s_pc_next;
  logic [1:0]  s_cnt_tomados, s_cnt_total;

  always #5 clk = ~clk;

  branch_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .pc_actual(pc_actual),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .alu_sub(alu_sub),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pc_next(pc_next), .pc_we(pc_we), .tomado(tomado), .busy(busy), .done(done),
    .illegal(illegal), .cnt_tomados(cnt_tomados), .cnt_total(cnt_total)
  );

  branch_sequencer #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .pc_actual(pc_actual),
    .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr), .alu_sub(s_alu_sub),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .pc_next(s_pc_next), .pc_we(s_pc_we), .tomado(s_tomado), .busy(s_busy), .done(s_done),
    .illegal(s_illegal), .cnt_tomados(s_cnt_tomados), .cnt_total(s_cnt_total)
  );

  logic [31:0] rf [32];
  logic [31:0] op_a, op_b, diff;
  logic        carry_o;

  // Behavioural ALU: real flags only while alu_sub is high, inverted
  // flags otherwise so sampling in the wrong cycle gives wrong answers.
  always_comb begin
    op_a = rf[rs1_addr];
    op_b = rf[rs2_addr];
    {carry_o, diff} = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;
    alu_zero  = (diff == 32'd0);
    alu_neg   = diff[31];
    alu_carry = carry_o;
    alu_ovf   = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
    if (!alu_sub) begin
      alu_zero  = !alu_zero;
      alu_neg   = !alu_neg;
      alu_carry = !alu_carry;
      alu_ovf   = !alu_ovf;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ill;
    logic        taken;
    logic [31:0] pc;
    int          issue_cyc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fails  = 0;
  int unsigned m_tom = 0;
  int unsigned m_tot = 0;

  // Scoreboard side: every done pops one expectation and checks it.
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      n_checks++;
      if ({s_rs1_addr, s_rs2_addr, s_alu_sub, s_pc_next, s_pc_we, s_tomado, s_busy, s_done, s_illegal} !==
          {rs1_addr, rs2_addr, alu_sub, pc_next, pc_we, tomado, busy, done, illegal}) begin
        n_fails++;
        $display("FAIL lockstep: small instance differs at cycle %0d", cyc);
      end
      if (pc_we && !done) begin
        n_checks++;
        n_fails++;
        $display("FAIL pc_we_without_done: pc_we=1 done=0 at cycle %0d", cyc);
      end
      if (done) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_done: done=1 with no pending branch at cycle %0d", cyc);
        end else begin
          mon_e = sbq.pop_front();
          if (!mon_e.ill) begin
            m_tot++;
            if (mon_e.taken) m_tom++;
          end
          if (illegal !== mon_e.ill) begin
            n_fails++;
            $display("FAIL illegal: got %b expected %b", illegal, mon_e.ill);
          end
          n_checks++;
          if (pc_we !== !mon_e.ill) begin
            n_fails++;
            $display("FAIL pc_we: got %b expected %b", pc_we, !mon_e.ill);
          end
          n_checks++;
          if (tomado !== mon_e.taken) begin
            n_fails++;
            $display("FAIL tomado: got %b expected %b", tomado, mon_e.taken);
          end
          if (!mon_e.ill) begin
            n_checks++;
            if (pc_next !== mon_e.pc) begin
              n_fails++;
              $display("FAIL pc_next: got %h expected %h", pc_next, mon_e.pc);
            end
          end
          n_checks++;
          if (cnt_tomados !== m_tom[15:0] || cnt_total !== m_tot[15:0]) begin
            n_fails++;
            $display("FAIL counters: got tom=%0d tot=%0d expected tom=%0d tot=%0d",
                     cnt_tomados, cnt_total, m_tom[15:0], m_tot[15:0]);
          end
          n_checks++;
          if (s_cnt_tomados !== m_tom[1:0] || s_cnt_total !== m_tot[1:0]) begin
            n_fails++;
            $display("FAIL counters_w2: got tom=%0d tot=%0d expected tom=%0d tot=%0d",
                     s_cnt_tomados, s_cnt_total, m_tom[1:0], m_tot[1:0]);
          end
          if (mon_e.issue_cyc >= 0) begin
            n_checks++;
            if (cyc - mon_e.issue_cyc != mon_e.lat) begin
              n_fails++;
              $display("FAIL latency: got %0d expected %0d", cyc - mon_e.issue_cyc, mon_e.lat);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] r1,
                                        input logic [4:0] r2, input int imm);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic e_ill,
                       input logic e_taken, input logic [31:0] e_pc, input int lat);
    exp_t e;
    e.ill = e_ill;
    e.taken = e_taken;
    e.pc = e_pc;
    e.issue_cyc = cyc;
    e.lat = lat;
    sbq.push_back(e);
    instr = ins;
    pc_actual = pc;
    start = 1'b1;
    tick();
    start = 1'b0;
    instr = $urandom;
    pc_actual = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (!done) begin
      n_fails++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
    end
    tick();
  endtask

  task automatic branch(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input int imm, input logic [31:0] pc);
    logic [31:0] a, b, tgt;
    logic c, ill;
    a = rf[r1];
    b = rf[r2];
    case (f3)
      3'b000:  c = (a == b);
      3'b001:  c = (a != b);
      3'b100:  c = ($signed(a) < $signed(b));
      3'b101:  c = ($signed(a) >= $signed(b));
      3'b110:  c = (a < b);
      default: c = (a >= b);
    endcase
    tgt = pc + 32'(imm);
    ill = c && tgt[1];
    issue(enc_b(f3, r1, r2, imm), pc, ill, ill ? 1'b0 : c, c ? tgt : pc + 32'd4, 4);
    wait_done("branch");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    instr = '0;
    pc_actual = '0;
    tick();
    tick();
    n_checks++;
    if ({busy, done, pc_we, illegal, tomado, alu_sub} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, pc_we, illegal, tomado, alu_sub});
    end
    n_checks++;
    if (pc_next !== 32'd0 || rs1_addr !== 5'd0 || rs2_addr !== 5'd0) begin
      n_fails++;
      $display("FAIL reset_regs: got pc=%h rs1=%0d rs2=%0d expected 0", pc_next, rs1_addr, rs2_addr);
    end
    n_checks++;
    if (cnt_tomados !== 16'd0 || cnt_total !== 16'd0) begin
      n_fails++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt_tomados, cnt_total);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_beq_taken();
    branch(3'b000, 5'd1, 5'd2, 16, 32'h100);
    n_checks++;
    if (tomado !== 1'b1 || pc_next !== 32'h110) begin
      n_fails++;
      $display("FAIL beq_hold: got tomado=%b pc=%h expected 1 00000110", tomado, pc_next);
    end
  endtask

  task automatic test_bne_not_taken();
    branch(3'b001, 5'd1, 5'd2, -8, 32'h200);
  endtask

  task automatic test_reset_mid();
    instr = enc_b(3'b000, 5'd1, 5'd2, 16);
    pc_actual = 32'h180;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if (alu_sub !== 1'b1) begin
      n_fails++;
      $display("FAIL mid_compara: got alu_sub=%b expected 1", alu_sub);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0 || pc_we !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_abort: got busy=%b pc_we=%b expected 0 0", busy, pc_we);
    end
    rst = 1'b0;
    m_tom = 0;
    m_tot = 0;
    repeat (6) tick();
    n_checks++;
    if (cnt_tomados !== 16'd0 || cnt_total !== 16'd0 || pc_next !== 32'd0) begin
      n_fails++;
      $display("FAIL mid_state: got tom=%0d tot=%0d pc=%h expected 0 0 0", cnt_tomados, cnt_total, pc_next);
    end
  endtask

  task automatic test_signed_unsigned();
    branch(3'b100, 5'd3, 5'd4, 32, 32'h300);
    branch(3'b110, 5'd3, 5'd4, 32, 32'h300);
    branch(3'b101, 5'd3, 5'd4, 32, 32'h300);
    branch(3'b111, 5'd3, 5'd4, 32, 32'h300);
    branch(3'b100, 5'd6, 5'd4, 64, 32'h340);
    branch(3'b000, 5'd5, 5'd4, 64, 32'h380);
    branch(3'b001, 5'd5, 5'd4, -4096, 32'h10);
  endtask

  task automatic test_illegal();
    logic [31:0] ins;
    issue(enc_b(3'b010, 5'd1, 5'd2, 16), 32'h400, 1'b1, 1'b0, 32'h0, 1);
    wait_done("illegal_f3");
    ins = enc_b(3'b000, 5'd1, 5'd2, 16);
    ins[6:0] = 7'b0110011;
    issue(ins, 32'h404, 1'b1, 1'b0, 32'h0, 1);
    wait_done("illegal_opc");
    issue(enc_b(3'b011, 5'd1, 5'd2, 16), 32'h408, 1'b1, 1'b0, 32'h0, 1);
    wait_done("illegal_f3b");
    branch(3'b000, 5'd1, 5'd2, 6, 32'h500);
    branch(3'b001, 5'd1, 5'd2, 6, 32'h504);
    n_checks++;
    if (cnt_total !== m_tot[15:0] || tomado !== 1'b0) begin
      n_fails++;
      $display("FAIL illegal_after: got tot=%0d tomado=%b expected %0d 0", cnt_total, tomado, m_tot[15:0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int d[3];
    int nd = 0;
    int n = 0;
    e.ill = 1'b0;
    e.taken = 1'b1;
    e.pc = 32'h608;
    e.issue_cyc = -1;
    e.lat = 4;
    repeat (3) sbq.push_back(e);
    instr = enc_b(3'b000, 5'd1, 5'd2, 8);
    pc_actual = 32'h600;
    start = 1'b1;
    while (nd < 3 && n < 40) begin
      tick();
      n++;
      if (done) begin
        d[nd] = cyc;
        nd++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (nd != 3) begin
      n_fails++;
      $display("FAIL b2b_count: got %0d done pulses expected 3", nd);
    end else begin
      n_checks++;
      if (d[1] - d[0] != 5 || d[2] - d[1] != 5) begin
        n_fails++;
        $display("FAIL b2b_spacing: got %0d,%0d expected 5,5", d[1] - d[0], d[2] - d[1]);
      end
    end
    repeat (8) tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++;
      $display("FAIL b2b_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_counter_wrap();
    for (int i = 0; i < 5; i++) begin
      branch(3'b000, 5'd1, 5'd2, 4 * (i + 1), 32'h700 + 32'(16 * i));
    end
    n_checks++;
    if (s_cnt_tomados !== m_tom[1:0] || s_cnt_total !== m_tot[1:0]) begin
      n_fails++;
      $display("FAIL wrap: got %0d/%0d expected %0d/%0d", s_cnt_tomados, s_cnt_total, m_tom[1:0], m_tot[1:0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'h0;
    rf[1] = 32'h5;
    rf[2] = 32'h5;
    rf[3] = 32'hFFFF_FFFF;
    rf[4] = 32'h1;
    rf[5] = 32'h7;
    rf[6] = 32'h8000_0000;
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_reset_mid();
    test_signed_unsigned();
    test_illegal();
    test_back_to_back();
    test_counter_wrap();
    repeat (3) tick();
    n_checks++;
    if (sbq.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
